// File: rtl/sensor_conditioner_pkg.sv
// rtl/sensor_conditioner_pkg.sv - shared channel indices, fault codes and fault FSM states
package sensor_conditioner_pkg;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned CH_PG    = 0;
    localparam int unsigned CH_CH    = 1;
    localparam int unsigned CH_RO    = 2;
    localparam int unsigned CH_START = 3;

    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_CH   = 2'b01;
    localparam logic [1:0] FAULT_JAM  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_F_CH  = 2'b01,
        ST_F_JAM = 2'b10
    } fault_state_e;

    // Fault code is a pure decode of the latched fault state.
    function automatic logic [1:0] fault_code_of(input fault_state_e st);
        logic [1:0] code;
        code = FAULT_NONE;
        case (st)
            ST_F_CH:  code = FAULT_CH;
            ST_F_JAM: code = FAULT_JAM;
            default:  code = FAULT_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sensor_conditioner_debounce_channel.sv
// rtl/sensor_conditioner_debounce_channel.sv - 2-FF sync, debounce and edge pulses for one input
module sensor_conditioner_debounce_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Two-stage synchroniser for the asynchronous raw input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after the synced value disagrees for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Level and edge pulses update together so a pulse marks the first cycle of the new level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - sensor front-end: debounce, edge pulses, plausibility/jam faults
module sensor_conditioner
    import sensor_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PLAUS_CYCLES    = 64,
    parameter int unsigned JAM_CYCLES      = 4096,
    parameter int unsigned CNT_W           = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_pg,
    input  logic       raw_ch,
    input  logic       raw_ro,
    input  logic       raw_start_n,
    input  logic       M,
    input  logic       fault_clr,
    output logic       pg,
    output logic       ch,
    output logic       ro,
    output logic       pg_rise,
    output logic       pg_fall,
    output logic       start_pulse,
    output logic       fault,
    output logic [1:0] fault_code
);

    logic [NUM_CH-1:0] raw_w;
    logic [NUM_CH-1:0] level_w;
    logic [NUM_CH-1:0] rise_w;
    logic [NUM_CH-1:0] fall_w;
    logic              unused_edges;

    // Button is active-low; invert so a press is treated as a rising level.
    assign raw_w[CH_PG]    = raw_pg;
    assign raw_w[CH_CH]    = raw_ch;
    assign raw_w[CH_RO]    = raw_ro;
    assign raw_w[CH_START] = ~raw_start_n;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sensor_conditioner_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (raw_w[g]),
            .level_o (level_w[g]),
            .rise_o  (rise_w[g]),
            .fall_o  (fall_w[g])
        );
    end

    assign unused_edges = ^{rise_w[CH_CH], fall_w[CH_CH], rise_w[CH_RO], fall_w[CH_RO],
                            fall_w[CH_START], level_w[CH_START]};

    assign pg          = level_w[CH_PG];
    assign ch          = level_w[CH_CH];
    assign ro          = level_w[CH_RO];
    assign pg_rise     = rise_w[CH_PG];
    assign pg_fall     = fall_w[CH_PG];
    assign start_pulse = rise_w[CH_START];

    fault_state_e     state_q, state_d;
    logic [CNT_W-1:0] t_ch_q, t_ch_d;
    logic [CNT_W-1:0] t_jam_q, t_jam_d;
    logic             cond_ch, cond_jam;

    assign cond_ch  = ch & ~pg;
    assign cond_jam = pg & M;

    // Fault state and timers; timers only run while no fault is latched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            t_ch_q  <= '0;
            t_jam_q <= '0;
        end else begin
            state_q <= state_d;
            t_ch_q  <= t_ch_d;
            t_jam_q <= t_jam_d;
        end
    end

    // Next-state: saturating timers in IDLE, CH-without-PG has priority over jam, clear returns to IDLE.
    always_comb begin
        state_d = state_q;
        t_ch_d  = '0;
        t_jam_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (cond_ch) begin
                    t_ch_d = (t_ch_q == '1) ? t_ch_q : t_ch_q + CNT_W'(1);
                end
                if (cond_jam) begin
                    t_jam_d = (t_jam_q == '1) ? t_jam_q : t_jam_q + CNT_W'(1);
                end
                if (cond_ch && (t_ch_q == CNT_W'(PLAUS_CYCLES - 1))) begin
                    state_d = ST_F_CH;
                    t_ch_d  = '0;
                    t_jam_d = '0;
                end else if (cond_jam && (t_jam_q == CNT_W'(JAM_CYCLES - 1))) begin
                    state_d = ST_F_JAM;
                    t_ch_d  = '0;
                    t_jam_d = '0;
                end
            end
            ST_F_CH, ST_F_JAM: begin
                if (fault_clr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fault_code = fault_code_of(state_q);
    assign fault      = |fault_code;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - directed self-checking bench for sensor_conditioner
module tb_sensor_conditioner;

    logic       clk;
    logic       reset;
    logic       raw_pg, raw_ch, raw_ro, raw_start_n, M, fault_clr;
    logic       pg, ch, ro, pg_rise, pg_fall, start_pulse, fault;
    logic [1:0] fault_code;

    int n_checks;
    int n_fail;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .PLAUS_CYCLES    (8),
        .JAM_CYCLES      (16),
        .CNT_W           (13)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .raw_pg      (raw_pg),
        .raw_ch      (raw_ch),
        .raw_ro      (raw_ro),
        .raw_start_n (raw_start_n),
        .M           (M),
        .fault_clr   (fault_clr),
        .pg          (pg),
        .ch          (ch),
        .ro          (ro),
        .pg_rise     (pg_rise),
        .pg_fall     (pg_fall),
        .start_pulse (start_pulse),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        reset = 1'b1; raw_pg = 0; raw_ch = 0; raw_ro = 0; raw_start_n = 1; M = 0; fault_clr = 0;
        tick(); tick();
        obs = {pg, ch, ro, pg_rise, pg_fall, start_pulse, fault, fault_code};
        n_checks++;
        if (obs !== 9'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, 9'b0);
        end
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            obs = {pg, ch, ro, pg_rise, pg_fall, start_pulse, fault, fault_code};
            n_checks++;
            if (obs !== 9'b0) begin
                n_fail++; $display("FAIL post_reset_idle cycle %0d: got %b expected %b", i, obs, 9'b0);
            end
        end
    endtask

    task automatic test_pg_edges();
        raw_pg = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if ({pg, pg_rise, pg_fall} !== {1'(i >= 6), 1'(i == 6), 1'b0}) begin
                n_fail++; $display("FAIL pg_rise cycle %0d: got pg/rise/fall=%b expected %b", i,
                                   {pg, pg_rise, pg_fall}, {1'(i >= 6), 1'(i == 6), 1'b0});
            end
        end
        raw_pg = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if ({pg, pg_rise, pg_fall} !== {1'(i < 6), 1'b0, 1'(i == 6)}) begin
                n_fail++; $display("FAIL pg_fall cycle %0d: got pg/rise/fall=%b expected %b", i,
                                   {pg, pg_rise, pg_fall}, {1'(i < 6), 1'b0, 1'(i == 6)});
            end
        end
    endtask

    task automatic test_ro();
        raw_ro = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if (ro !== 1'(i >= 6)) begin
                n_fail++; $display("FAIL ro_level cycle %0d: got %b expected %b", i, ro, 1'(i >= 6));
            end
        end
        raw_ro = 1'b0;
        for (int i = 1; i <= 6; i++) tick();
        n_checks++;
        if (ro !== 1'b0) begin
            n_fail++; $display("FAIL ro_release: got %b expected 0", ro);
        end
    endtask

    task automatic test_ch_glitch();
        raw_ch = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) raw_ch = 1'b0;
            tick();
            n_checks++;
            if ({ch, fault_code} !== 3'b000) begin
                n_fail++; $display("FAIL ch_glitch3 cycle %0d: got ch/code=%b expected 000", i, {ch, fault_code});
            end
        end
        raw_ch = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            if (i == 5) raw_ch = 1'b0;
            tick();
            n_checks++;
            if ({ch, fault_code} !== {1'(i >= 6 && i < 10), 2'b00}) begin
                n_fail++; $display("FAIL ch_glitch4 cycle %0d: got ch/code=%b expected %b", i,
                                   {ch, fault_code}, {1'(i >= 6 && i < 10), 2'b00});
            end
        end
    endtask

    task automatic test_start_bounce();
        logic [6:0] bounce;
        int pulses;
        bounce = 7'b0101010;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            raw_start_n = (i < 7) ? bounce[6 - i] : 1'b0;
            tick();
            if (start_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++; $display("FAIL start_press_pulses: got %0d expected 1", pulses);
        end
        raw_start_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (start_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL start_release_pulses: got %0d expected 0", pulses);
        end
    endtask

    task automatic test_ch_fault();
        bit seen;
        seen = 0;
        raw_ch = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (ch === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL ch_fault_wait: got ch=%b expected 1 within 20 cycles", ch);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if ({fault, fault_code} !== ((i == 8) ? 3'b101 : 3'b000)) begin
                n_fail++; $display("FAIL ch_fault_latch cycle %0d: got %b expected %b", i,
                                   {fault, fault_code}, (i == 8) ? 3'b101 : 3'b000);
            end
        end
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_checks++;
        if (fault_code !== 2'b00) begin
            n_fail++; $display("FAIL ch_fault_clear: got %b expected 00", fault_code);
        end
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (fault_code !== ((i == 8) ? 2'b01 : 2'b00)) begin
                n_fail++; $display("FAIL ch_fault_relatch cycle %0d: got %b expected %b", i,
                                   fault_code, (i == 8) ? 2'b01 : 2'b00);
            end
        end
        raw_ch = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        tick();
        n_checks++;
        if ({ch, fault_code} !== 3'b000) begin
            n_fail++; $display("FAIL ch_fault_cleanup: got ch/code=%b expected 000", {ch, fault_code});
        end
    endtask

    task automatic test_jam();
        raw_pg = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (pg !== 1'b1) begin
            n_fail++; $display("FAIL jam_pg_setup: got %b expected 1", pg);
        end
        M = 1'b1;
        for (int i = 1; i <= 15; i++) tick();
        M = 1'b0;
        tick();
        n_checks++;
        if (fault_code !== 2'b00) begin
            n_fail++; $display("FAIL jam_drop_at_15: got %b expected 00", fault_code);
        end
        M = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            fault_clr = (i == 8);
            tick();
            n_checks++;
            if ({fault, fault_code} !== ((i == 16) ? 3'b110 : 3'b000)) begin
                n_fail++; $display("FAIL jam_latch cycle %0d: got %b expected %b", i,
                                   {fault, fault_code}, (i == 16) ? 3'b110 : 3'b000);
            end
        end
        fault_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [8:0] obs;
        raw_ro = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        #1;
        obs = {pg, ch, ro, pg_rise, pg_fall, start_pulse, fault, fault_code};
        n_checks++;
        if (obs !== 9'b0) begin
            n_fail++; $display("FAIL reset_mid_async: got %b expected %b", obs, 9'b0);
        end
        M = 1'b0;
        raw_ro = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            obs = {pg, ch, ro, pg_rise, pg_fall, start_pulse, fault, fault_code};
            n_checks++;
            if (obs !== {1'(i >= 6), 2'b00, 1'(i == 6), 5'b0}) begin
                n_fail++; $display("FAIL reset_mid_recover cycle %0d: got %b expected %b", i, obs,
                                   {1'(i >= 6), 2'b00, 1'(i == 6), 5'b0});
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_pg_edges();
        test_ro();
        test_ch_glitch();
        test_start_bounce();
        test_ch_fault();
        test_jam();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
